// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with write-to-read bypass and a
// write-pending scoreboard. x0 reads as zero and is never marked pending.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int AW    = $clog2(NREG),
    parameter int NREAD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic                  alloc_valid,
    input  logic [AW-1:0]         alloc_rd,
    output logic                  alloc_ready,
    input  logic                  flush,
    output logic [AW:0]           busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic            wr_en;
    logic            alloc_fire;
    logic            alloc_set;
    logic            cnt_inc;
    logic            cnt_dec;
    logic [AW-1:0]   ra;

    // Allocation handshake: the issue side holds alloc_valid/alloc_rd; the
    // allocation fires on a clock edge where alloc_valid && alloc_ready.
    // alloc_ready depends only on reset, flush, alloc_rd and the writeback
    // port, never on alloc_valid. A busy destination is accepted only when
    // this cycle's writeback retires it.
    assign wr_en       = we && (waddr != '0);
    assign alloc_ready = reset && !flush &&
                         ((alloc_rd == '0) || !busy[alloc_rd] || (we && (waddr == alloc_rd)));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_set   = alloc_fire && (alloc_rd != '0);

    // Count deltas: a set of an idle bit adds one; a retire of a busy bit
    // subtracts one unless a new producer re-claims the same register.
    assign cnt_inc = alloc_set && !busy[alloc_rd];
    assign cnt_dec = wr_en && busy[waddr] && !(alloc_set && (alloc_rd == waddr));

    // Next busy vector: flush clears everything, otherwise writeback clears
    // and allocation sets, with allocation winning on the same register.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = busy_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
        if (flush) begin
            busy_nxt = '0;
            cnt_nxt  = '0;
        end else begin
            if (wr_en)     busy_nxt[waddr]    = 1'b0;
            if (alloc_set) busy_nxt[alloc_rd] = 1'b1;
        end
    end

    // Register array; x0 is never written so it stays at its reset zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Scoreboard state and its running population count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Combinational read ports with same-cycle writeback bypass; forced to
    // zero while reset is asserted.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = raddr[k*AW +: AW];
            if (reset && (ra != '0)) begin
                if (we && (waddr == ra)) begin
                    rdata[k*XLEN +: XLEN] = wdata;
                end else begin
                    rdata[k*XLEN +: XLEN] = regs[ra];
                    rbusy[k]              = busy[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks on a default regfile_sb plus a reference
// model run on a 4-port, 64-bit, 16-register instance.
module tb_regfile_sb;

    localparam int XLEN = 32, NREG = 32, AW = 5, NREAD = 2;
    localparam int XW = 64, NW = 16, AWW = 4, NRW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // default instance signals
    logic [NREAD*AW-1:0]   raddr;
    logic [NREAD*XLEN-1:0] rdata;
    logic [NREAD-1:0]      rbusy;
    logic                  we, alloc_valid, alloc_ready, flush;
    logic [AW-1:0]         waddr, alloc_rd;
    logic [XLEN-1:0]       wdata;
    logic [AW:0]           busy_cnt;

    // wide instance signals
    logic [NRW*AWW-1:0]    w_raddr;
    logic [NRW*XW-1:0]     w_rdata;
    logic [NRW-1:0]        w_rbusy;
    logic                  w_we, w_alloc_valid, w_alloc_ready, w_flush;
    logic [AWW-1:0]        w_waddr, w_alloc_rd;
    logic [XW-1:0]         w_wdata;
    logic [AWW:0]          w_busy_cnt;

    regfile_sb dut (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .we(we), .waddr(waddr), .wdata(wdata), .alloc_valid(alloc_valid),
        .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .flush(flush),
        .busy_cnt(busy_cnt)
    );

    regfile_sb #(.XLEN(XW), .NREG(NW), .NREAD(NRW)) dut_w (
        .clk(clk), .reset(reset), .raddr(w_raddr), .rdata(w_rdata), .rbusy(w_rbusy),
        .we(w_we), .waddr(w_waddr), .wdata(w_wdata), .alloc_valid(w_alloc_valid),
        .alloc_rd(w_alloc_rd), .alloc_ready(w_alloc_ready), .flush(w_flush),
        .busy_cnt(w_busy_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_reg [NW];
    logic [NW-1:0] m_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
        alloc_valid = 1'b0; alloc_rd = '0; flush = 1'b0;
    endtask

    task automatic idle_w();
        w_raddr = '0; w_we = 1'b0; w_waddr = '0; w_wdata = '0;
        w_alloc_valid = 1'b0; w_alloc_rd = '0; w_flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
    endtask

    task automatic do_alloc(input logic [AW-1:0] a);
        alloc_valid = 1'b1; alloc_rd = a;
    endtask

    function automatic logic [63:0] rd(input int p);
        return {32'd0, rdata[p*XLEN +: XLEN]};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        idle();
        idle_w();
        for (int i = 0; i < NW; i++) m_reg[i] = '0;
        m_busy = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cnt_in_reset", busy_cnt, 0);
        check("rst_ready_in_reset", alloc_ready, 0);
        reset = 1'b1;
        #1;

        // 1. all addresses read as zero after reset
        for (int a = 0; a < NREG; a++) begin
            set_rd(0, a[AW-1:0]);
            set_rd(1, a[AW-1:0]);
            #0.1;
            check("rst_rdata0", rd(0), 0);
            check("rst_rdata1", rd(1), 0);
            check("rst_rbusy", rbusy, 0);
        end
        check("rst_busy_cnt", busy_cnt, 0);
        tick();

        // 2. bypass, array read-back, x0 discard
        idle();
        do_write(5, 32'hDEADBEEF);
        set_rd(0, 5);
        #1;
        check("byp_r5", rd(0), 64'hDEADBEEF);
        check("byp_r5_busy", rbusy[0], 0);
        tick();
        idle();
        set_rd(0, 5);
        #1;
        check("arr_r5", rd(0), 64'hDEADBEEF);
        do_write(0, 32'h1234);
        set_rd(0, 0);
        #1;
        check("x0_byp", rd(0), 0);
        check("x0_busy", rbusy[0], 0);
        tick();
        idle();
        #1;
        check("x0_after", rd(0), 0);

        // 3. allocate r7, re-alloc blocked, writeback clears
        do_alloc(7);
        #1;
        check("alloc7_ready", alloc_ready, 1);
        tick();
        idle();
        set_rd(0, 7);
        #1;
        check("r7_busy", rbusy[0], 1);
        check("cnt_1", busy_cnt, 1);
        do_alloc(7);
        #1;
        check("realloc7_ready", alloc_ready, 0);
        alloc_valid = 1'b0;
        do_write(7, 32'h55);
        #1;
        check("wb7_byp", rd(0), 64'h55);
        check("wb7_busy", rbusy[0], 0);
        check("wb7_ready", alloc_ready, 1);
        tick();
        idle();
        set_rd(0, 7);
        #1;
        check("cnt_0", busy_cnt, 0);
        check("r7_arr", rd(0), 64'h55);
        check("r7_idle", rbusy[0], 0);

        // 4. same-cycle writeback and allocation on busy r9
        do_alloc(9);
        tick();
        idle();
        #1;
        check("r9_cnt1", busy_cnt, 1);
        do_write(9, 32'h9999);
        do_alloc(9);
        #1;
        check("r9_both_ready", alloc_ready, 1);
        tick();
        idle();
        set_rd(0, 9);
        #1;
        check("r9_busy", rbusy[0], 1);
        check("r9_data", rd(0), 64'h9999);
        check("r9_cnt_same", busy_cnt, 1);
        do_write(9, 32'h1);
        tick();
        idle();
        #1;
        check("r9_retired", busy_cnt, 0);

        // 5. flush with concurrent writeback and blocked allocation
        do_alloc(1); tick();
        do_alloc(2); tick();
        do_alloc(3); tick();
        idle();
        #1;
        check("cnt_3", busy_cnt, 3);
        flush = 1'b1;
        do_write(4, 32'hAA);
        do_alloc(6);
        #1;
        check("flush_ready", alloc_ready, 0);
        tick();
        idle();
        set_rd(0, 1);
        set_rd(1, 2);
        #1;
        check("flush_cnt", busy_cnt, 0);
        check("flush_rbusy12", rbusy, 0);
        set_rd(0, 3);
        set_rd(1, 4);
        #1;
        check("flush_r3", rbusy[0], 0);
        check("flush_r4", rd(1), 64'hAA);
        set_rd(0, 6);
        #1;
        check("flush_r6", rbusy[0], 0);

        // 1b. mid-cycle asynchronous reset with live state
        do_alloc(10);
        tick();
        idle();
        set_rd(0, 4);
        set_rd(1, 5);
        do_write(4, 32'h77);
        do_alloc(3);
        #1;
        reset = 1'b0;
        #1;
        check("async_rdata0", rd(0), 0);
        check("async_rdata1", rd(1), 0);
        check("async_rbusy", rbusy, 0);
        check("async_cnt", busy_cnt, 0);
        check("async_ready", alloc_ready, 0);
        tick();
        idle();
        set_rd(0, 4);
        set_rd(1, 3);
        reset = 1'b1;
        #1;
        check("release_r4", rd(0), 0);
        check("release_r3_busy", rbusy[1], 0);
        check("release_cnt", busy_cnt, 0);
        tick();

        // 6. wide instance against the reference model
        for (int c = 0; c < 400; c++) begin
            logic [AWW-1:0] a;
            logic [63:0]    e;
            logic           eb, e_ready;
            w_we          = 1'($urandom_range(0, 1));
            w_waddr       = AWW'($urandom_range(0, NW-1));
            w_wdata       = {$urandom, $urandom};
            w_alloc_valid = 1'($urandom_range(0, 1));
            w_alloc_rd    = ($urandom_range(0, 3) == 0) ? w_waddr : AWW'($urandom_range(0, NW-1));
            w_flush       = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < NRW; p++) begin
                a = AWW'($urandom_range(0, NW-1));
                if ($urandom_range(0, 3) == 0) a = w_waddr;
                w_raddr[p*AWW +: AWW] = a;
            end
            #1;
            for (int p = 0; p < NRW; p++) begin
                a = w_raddr[p*AWW +: AWW];
                if (a == 0) begin
                    e = 0; eb = 0;
                end else if (w_we && w_waddr == a) begin
                    e = w_wdata; eb = 0;
                end else begin
                    e = m_reg[a]; eb = m_busy[a];
                end
                exp_q.push_back(e);
                exp_q.push_back({63'd0, eb});
            end
            e_ready = !w_flush && (w_alloc_rd == 0 || !m_busy[w_alloc_rd] ||
                                   (w_we && w_waddr == w_alloc_rd));
            for (int p = 0; p < NRW; p++) begin
                check("sw_rdata", w_rdata[p*XW +: XW], exp_q.pop_front());
                check("sw_rbusy", {63'd0, w_rbusy[p]}, exp_q.pop_front());
            end
            check("sw_ready", w_alloc_ready, e_ready);
            check("sw_cnt", w_busy_cnt, $countones(m_busy));
            tick();
            if (w_we && w_waddr != 0) m_reg[w_waddr] = w_wdata;
            if (w_flush) begin
                m_busy = '0;
            end else begin
                if (w_we && w_waddr != 0) m_busy[w_waddr] = 1'b0;
                if (w_alloc_valid && e_ready && w_alloc_rd != 0) m_busy[w_alloc_rd] = 1'b1;
            end
        end
        idle_w();
        #1;
        check("sw_final_cnt", w_busy_cnt, $countones(m_busy));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
